// File: rtl/main_decoder.sv
// Opcode encodings shared by the decoders, plus the main control decoder.
// The decoder maps the 7-bit RV32I opcode to the datapath control word and
// registers it, so the word stays stable for a whole cycle.

package Opcode_pkg;

  typedef logic [6:0] OpCode_t;

  localparam OpCode_t opLw    = 7'b0000011;
  localparam OpCode_t opSw    = 7'b0100011;
  localparam OpCode_t opRType = 7'b0110011;
  localparam OpCode_t opBeq   = 7'b1100011;
  localparam OpCode_t opAddi  = 7'b0010011;
  localparam OpCode_t opJal   = 7'b1101111;
  localparam OpCode_t opNop   = 7'b0000000;

endpackage

module main_decoder
  import Opcode_pkg::*;
(
  input  logic           i_Clk,
  input  logic           i_Rst_n,
  input  OpCode_t        i_OpCode,
  output logic           o_RegWrite,
  output logic [1:0]     o_ImmSrc,
  output logic           o_ALUSrc,
  output logic           o_MemWrite,
  output logic [1:0]     o_ResultSrc,
  output logic           o_Branch,
  output logic           o_Jump,
  output logic [1:0]     o_ALUOp,
  output logic           o_Illegal
);

  typedef struct packed {
    logic       regWrite;
    logic [1:0] immSrc;
    logic       aluSrc;
    logic       memWrite;
    logic [1:0] resultSrc;
    logic       branch;
    logic       jump;
    logic [1:0] aluOp;
    logic       illegal;
  } ctrlWord_t;

  // All-zero word: nothing written, PC not redirected.
  localparam ctrlWord_t safeWord = '0;

  ctrlWord_t nextWord;
  ctrlWord_t ctrlReg;

  // Combinational opcode decode; textbook don't-cares are pinned to 0.
  always_comb begin
    nextWord = safeWord;
    unique case (i_OpCode)
      opLw: begin
        nextWord.regWrite  = 1'b1;
        nextWord.immSrc    = 2'b00;
        nextWord.aluSrc    = 1'b1;
        nextWord.resultSrc = 2'b01;
        nextWord.aluOp     = 2'b00;
      end
      opSw: begin
        nextWord.immSrc    = 2'b01;
        nextWord.aluSrc    = 1'b1;
        nextWord.memWrite  = 1'b1;
        nextWord.aluOp     = 2'b00;
      end
      opRType: begin
        nextWord.regWrite  = 1'b1;
        nextWord.aluOp     = 2'b10;
      end
      opBeq: begin
        nextWord.immSrc    = 2'b10;
        nextWord.branch    = 1'b1;
        nextWord.aluOp     = 2'b01;
      end
      opAddi: begin
        nextWord.regWrite  = 1'b1;
        nextWord.aluSrc    = 1'b1;
        nextWord.aluOp     = 2'b10;
      end
      opJal: begin
        nextWord.regWrite  = 1'b1;
        nextWord.immSrc    = 2'b11;
        nextWord.resultSrc = 2'b10;
        nextWord.jump      = 1'b1;
      end
      opNop: begin
        nextWord = safeWord;
      end
      default: begin
        nextWord         = safeWord;
        nextWord.illegal = 1'b1;
      end
    endcase
  end

  // Capture the decoded word every edge; reset clears it immediately.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      ctrlReg <= safeWord;
    end else begin
      ctrlReg <= nextWord;
    end
  end

  assign o_RegWrite  = ctrlReg.regWrite;
  assign o_ImmSrc    = ctrlReg.immSrc;
  assign o_ALUSrc    = ctrlReg.aluSrc;
  assign o_MemWrite  = ctrlReg.memWrite;
  assign o_ResultSrc = ctrlReg.resultSrc;
  assign o_Branch    = ctrlReg.branch;
  assign o_Jump      = ctrlReg.jump;
  assign o_ALUOp     = ctrlReg.aluOp;
  assign o_Illegal   = ctrlReg.illegal;

endmodule

// File: tb/tb_main_decoder.sv
// Directed bench for main_decoder. Control words are written as 13-bit
// literals: RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, Jump,
// ALUOp, Illegal.

module tb_main_decoder;

  logic       i_Clk;
  logic       i_Rst_n;
  logic [6:0] i_OpCode;
  logic       o_RegWrite;
  logic [1:0] o_ImmSrc;
  logic       o_ALUSrc;
  logic       o_MemWrite;
  logic [1:0] o_ResultSrc;
  logic       o_Branch;
  logic       o_Jump;
  logic [1:0] o_ALUOp;
  logic       o_Illegal;

  int checkCount = 0;
  int errorCount = 0;

  localparam logic [12:0] wLw    = 13'b1_00_1_0_01_0_0_00_0;
  localparam logic [12:0] wSw    = 13'b0_01_1_1_00_0_0_00_0;
  localparam logic [12:0] wRType = 13'b1_00_0_0_00_0_0_10_0;
  localparam logic [12:0] wBeq   = 13'b0_10_0_0_00_1_0_01_0;
  localparam logic [12:0] wAddi  = 13'b1_00_1_0_00_0_0_10_0;
  localparam logic [12:0] wJal   = 13'b1_11_0_0_10_0_1_00_0;
  localparam logic [12:0] wZero  = 13'b0_00_0_0_00_0_0_00_0;
  localparam logic [12:0] wIll   = 13'b0_00_0_0_00_0_0_00_1;

  main_decoder dut (
    .i_Clk       (i_Clk),
    .i_Rst_n     (i_Rst_n),
    .i_OpCode    (i_OpCode),
    .o_RegWrite  (o_RegWrite),
    .o_ImmSrc    (o_ImmSrc),
    .o_ALUSrc    (o_ALUSrc),
    .o_MemWrite  (o_MemWrite),
    .o_ResultSrc (o_ResultSrc),
    .o_Branch    (o_Branch),
    .o_Jump      (o_Jump),
    .o_ALUOp     (o_ALUOp),
    .o_Illegal   (o_Illegal)
  );

  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running want finished");
    $fatal(1);
  end

  function automatic logic [12:0] ctrlWord();
    return {o_RegWrite, o_ImmSrc, o_ALUSrc, o_MemWrite, o_ResultSrc,
            o_Branch, o_Jump, o_ALUOp, o_Illegal};
  endfunction

  task automatic checkVal(input string tag, input logic [12:0] obs,
                          input logic [12:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic applyCheck(input string tag, input logic [6:0] op,
                            input logic [12:0] exp);
    i_OpCode = op;
    stepCycle();
    checkVal(tag, ctrlWord(), exp);
  endtask

  typedef struct {
    string      tag;
    logic [6:0] op;
    logic [12:0] word;
  } vec_t;

  vec_t sweep[7];
  vec_t illegalVec[4];
  logic legal;

  initial begin
    sweep[0] = '{"lw",     7'b0000011, wLw};
    sweep[1] = '{"sw",     7'b0100011, wSw};
    sweep[2] = '{"rtype",  7'b0110011, wRType};
    sweep[3] = '{"beq",    7'b1100011, wBeq};
    sweep[4] = '{"addi",   7'b0010011, wAddi};
    sweep[5] = '{"jal",    7'b1101111, wJal};
    sweep[6] = '{"nop",    7'b0000000, wZero};
    illegalVec[0] = '{"ill_7f", 7'b1111111, wIll};
    illegalVec[1] = '{"ill_37", 7'b0110111, wIll};
    illegalVec[2] = '{"ill_01", 7'b0000001, wIll};
    illegalVec[3] = '{"ill_clr_lw", 7'b0000011, wLw};

    // Reset held with lw presented across several edges.
    i_Rst_n  = 1'b0;
    i_OpCode = 7'b0000011;
    #2;
    checkVal("rst_async_start", ctrlWord(), wZero);
    repeat (3) stepCycle();
    checkVal("rst_held", ctrlWord(), wZero);

    // Release away from an edge; first decode on the next rising edge.
    @(negedge i_Clk);
    i_Rst_n = 1'b1;
    #1;
    checkVal("rst_release_no_edge", ctrlWord(), wZero);

    for (int i = 0; i < 7; i++) applyCheck(sweep[i].tag, sweep[i].op, sweep[i].word);

    i_OpCode = 7'b0000011;
    stepCycle();
    checkVal("lw_resultsrc", {11'd0, o_ResultSrc}, 13'd1);
    checkVal("lw_alusrc", {12'd0, o_ALUSrc}, 13'd1);
    i_OpCode = 7'b1101111;
    stepCycle();
    checkVal("jal_immsrc", {11'd0, o_ImmSrc}, 13'd3);
    checkVal("jal_resultsrc", {11'd0, o_ResultSrc}, 13'd2);
    checkVal("jal_jump", {12'd0, o_Jump}, 13'd1);

    for (int i = 0; i < 4; i++)
      applyCheck(illegalVec[i].tag, illegalVec[i].op, illegalVec[i].word);

    // Async reset mid-cycle after jal decoded.
    applyCheck("jal_before_rst", 7'b1101111, wJal);
    #2;
    i_Rst_n = 1'b0;
    #1;
    checkVal("rst_mid_cycle", ctrlWord(), wZero);
    stepCycle();
    checkVal("rst_mid_held", ctrlWord(), wZero);
    @(negedge i_Clk);
    i_Rst_n  = 1'b1;
    i_OpCode = 7'b0010011;
    stepCycle();
    checkVal("after_rst_addi", ctrlWord(), wAddi);

    // Opcode change between edges must not reach the outputs early.
    applyCheck("hold_sw", 7'b0100011, wSw);
    #2;
    i_OpCode = 7'b0110011;
    #1;
    checkVal("hold_sw_midcycle", ctrlWord(), wSw);
    stepCycle();
    checkVal("hold_then_rtype", ctrlWord(), wRType);

    // Every opcode: illegal flag, zero controls when illegal, exclusions.
    for (int i = 0; i < 128; i++) begin
      i_OpCode = 7'(i);
      stepCycle();
      legal = (i == 7'h03) || (i == 7'h23) || (i == 7'h33) || (i == 7'h63) ||
              (i == 7'h13) || (i == 7'h6F) || (i == 0);
      checkVal($sformatf("all_illegal_%0d", i), {12'd0, o_Illegal}, {12'd0, ~legal});
      if (!legal) checkVal($sformatf("all_zero_%0d", i), ctrlWord(), wIll);
      checkVal($sformatf("all_excl_%0d", i),
               {11'd0, o_Branch & o_Jump, o_MemWrite & o_RegWrite}, 13'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
